// File: rtl/alu_pwr_ctrl.sv
// Power-sequencing controller for the switchable ALU domain.
// Optional idle auto-sleep is enabled by defining ALU_AUTO_SLEEP_EN.
module alu_pwr_ctrl #(
    parameter int ISO_SETUP_CYCLES = 2,
    parameter int PWR_UP_CYCLES    = 8,
    parameter int IDLE_TIMEOUT     = 64,
    parameter int CNT_W            = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sleep_req,
    input  logic       wake_req,
    input  logic       start_in,
    input  logic       alu_busy,
    output logic       alu_start,
    output logic       alu_pwr_en,
    output logic       iso_en,
    output logic       alu_rst_n,
    output logic       ready,
    output logic       start_drop,
    output logic [2:0] pwr_state
);

    typedef enum logic [2:0] {
        S_ON      = 3'd0,
        S_DRAIN   = 3'd1,
        S_ISO     = 3'd2,
        S_OFF     = 3'd3,
        S_PWRUP   = 3'd4,
        S_RELEASE = 3'd5
    } state_t;

    localparam int MAX_A = (ISO_SETUP_CYCLES > PWR_UP_CYCLES) ?
                           ISO_SETUP_CYCLES : PWR_UP_CYCLES;
    localparam int MAX_B = (MAX_A > IDLE_TIMEOUT) ? MAX_A : IDLE_TIMEOUT;

    localparam logic [CNT_W-1:0] ISO_LAST = CNT_W'(ISO_SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(PWR_UP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(MAX_B - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic             cnt_run;
    logic             cnt_clr;
    logic             idle_tmo;

`ifdef ALU_AUTO_SLEEP_EN
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_TIMEOUT - 1);

    logic idle_act;

    // Any activity in ON restarts the idle window.
    always_comb begin
        idle_act = start_in | alu_busy | wake_req;
        idle_tmo = (state == S_ON) && !idle_act && (cnt == IDLE_LAST);
        cnt_clr  = (state == S_ON) && idle_act;
        cnt_run  = (state == S_ISO) || (state == S_PWRUP) ||
                   ((state == S_ON) && !idle_act);
    end
`else
    // Counter only times the ISO and PWRUP phases.
    always_comb begin
        idle_tmo = 1'b0;
        cnt_clr  = 1'b0;
        cnt_run  = (state == S_ISO) || (state == S_PWRUP);
    end
`endif

    // Next-state selection; wake requests win over sleep in ON.
    always_comb begin
        state_next = S_OFF;
        case (state)
            S_ON: begin
                if (!wake_req && (sleep_req || idle_tmo))
                    state_next = S_DRAIN;
                else
                    state_next = S_ON;
            end
            S_DRAIN: begin
                if (wake_req)
                    state_next = S_ON;
                else if (!alu_busy)
                    state_next = S_ISO;
                else
                    state_next = S_DRAIN;
            end
            S_ISO: begin
                state_next = (cnt == ISO_LAST) ? S_OFF : S_ISO;
            end
            S_OFF: begin
                state_next = wake_req ? S_PWRUP : S_OFF;
            end
            S_PWRUP: begin
                state_next = (cnt == PWR_LAST) ? S_RELEASE : S_PWRUP;
            end
            S_RELEASE: begin
                state_next = S_ON;
            end
            default: begin
                state_next = S_OFF;
            end
        endcase
    end

    // State, shared counter and registered Moore outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_OFF;
            cnt        <= '0;
            alu_pwr_en <= 1'b0;
            iso_en     <= 1'b1;
            alu_rst_n  <= 1'b0;
            ready      <= 1'b0;
        end else begin
            state <= state_next;
            if (state_next != state || cnt_clr)
                cnt <= '0;
            else if (cnt_run && cnt != CNT_SAT)
                cnt <= cnt + 1'b1;
            ready <= (state_next == S_ON);
            case (state_next)
                S_ON, S_DRAIN: begin
                    alu_pwr_en <= 1'b1;
                    iso_en     <= 1'b0;
                    alu_rst_n  <= 1'b1;
                end
                S_ISO, S_RELEASE: begin
                    alu_pwr_en <= 1'b1;
                    iso_en     <= 1'b1;
                    alu_rst_n  <= 1'b1;
                end
                S_PWRUP: begin
                    alu_pwr_en <= 1'b1;
                    iso_en     <= 1'b1;
                    alu_rst_n  <= 1'b0;
                end
                default: begin
                    alu_pwr_en <= 1'b0;
                    iso_en     <= 1'b1;
                    alu_rst_n  <= 1'b0;
                end
            endcase
        end
    end

    assign alu_start  = start_in & (state == S_ON);
    assign start_drop = start_in & (state != S_ON);
    assign pwr_state  = state;

endmodule

// File: tb/tb_alu_pwr_ctrl.sv
// Scoreboard bench for alu_pwr_ctrl: directed cycles push expected
// outputs; a negedge monitor pops and compares.
module tb_alu_pwr_ctrl;

    localparam logic [2:0] P_ON      = 3'd0;
    localparam logic [2:0] P_DRAIN   = 3'd1;
    localparam logic [2:0] P_ISO     = 3'd2;
    localparam logic [2:0] P_OFF     = 3'd3;
    localparam logic [2:0] P_PWRUP   = 3'd4;
    localparam logic [2:0] P_RELEASE = 3'd5;

    typedef struct packed {
        logic [2:0] st;
        logic       pe;
        logic       iso;
        logic       arn;
        logic       rdy;
        logic       as;
        logic       sd;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sleep_req;
    logic       wake_req;
    logic       start_in;
    logic       alu_busy;
    logic       alu_start;
    logic       alu_pwr_en;
    logic       iso_en;
    logic       alu_rst_n;
    logic       ready;
    logic       start_drop;
    logic [2:0] pwr_state;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   n_rec  = 0;

    always #5 clk = ~clk;

    alu_pwr_ctrl #(
        .ISO_SETUP_CYCLES(2),
        .PWR_UP_CYCLES   (8),
        .IDLE_TIMEOUT    (4),
        .CNT_W           (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sleep_req (sleep_req),
        .wake_req  (wake_req),
        .start_in  (start_in),
        .alu_busy  (alu_busy),
        .alu_start (alu_start),
        .alu_pwr_en(alu_pwr_en),
        .iso_en    (iso_en),
        .alu_rst_n (alu_rst_n),
        .ready     (ready),
        .start_drop(start_drop),
        .pwr_state (pwr_state)
    );

    // Monitor: compare each presented cycle against the queued record.
    always @(negedge clk) begin
        exp_t e;
        exp_t a;
        if (q.size() > 0) begin
            e = q.pop_front();
            a = {pwr_state, alu_pwr_en, iso_en, alu_rst_n,
                 ready, alu_start, start_drop};
            n_chk++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL rec%0d st/pe/iso/rstn/rdy/start/drop got %b %b%b%b%b%b%b need %b %b%b%b%b%b%b",
                         n_rec, a.st, a.pe, a.iso, a.arn, a.rdy, a.as, a.sd,
                         e.st, e.pe, e.iso, e.arn, e.rdy, e.as, e.sd);
            end
            n_rec++;
        end
    end

    // Drive one cycle of inputs and queue the outputs expected in it.
    task automatic cyc(input logic r, input logic sl, input logic wk,
                       input logic st, input logic bz, input logic [2:0] es);
        exp_t e;
        rst_n     = r;
        sleep_req = sl;
        wake_req  = wk;
        start_in  = st;
        alu_busy  = bz;
        e.st = es;
        case (es)
            P_ON, P_DRAIN:    {e.pe, e.iso, e.arn} = 3'b101;
            P_ISO, P_RELEASE: {e.pe, e.iso, e.arn} = 3'b111;
            P_PWRUP:          {e.pe, e.iso, e.arn} = 3'b110;
            default:          {e.pe, e.iso, e.arn} = 3'b010;
        endcase
        e.rdy = (es == P_ON);
        e.as  = st && (es == P_ON);
        e.sd  = st && (es != P_ON);
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Wake from OFF through the full power-up sequence.
    task automatic wake_up();
        cyc(1, 0, 1, 0, 0, P_OFF);
        for (int i = 0; i < 8; i++)
            cyc(1, (i == 3), 0, 0, 0, P_PWRUP);
        cyc(1, 0, 0, 0, 0, P_RELEASE);
    endtask

    initial begin
        rst_n     = 1'b0;
        sleep_req = 1'b0;
        wake_req  = 1'b0;
        start_in  = 1'b0;
        alu_busy  = 1'b0;
        @(posedge clk);
        #1;
        cyc(0, 0, 0, 0, 0, P_OFF);
        cyc(0, 0, 1, 0, 0, P_OFF);
        cyc(1, 0, 0, 0, 0, P_OFF);
        cyc(1, 1, 0, 0, 0, P_OFF);
        cyc(1, 0, 0, 1, 0, P_OFF);

        wake_up();
        cyc(1, 0, 0, 1, 0, P_ON);
        for (int i = 0; i < 5; i++)
            cyc(1, 0, 0, 0, 1, P_ON);
        cyc(1, 1, 0, 0, 1, P_ON);
        for (int i = 0; i < 3; i++)
            cyc(1, 1, 0, 0, 1, P_DRAIN);
        cyc(1, 1, 0, 0, 0, P_DRAIN);
        cyc(1, 0, 0, 1, 0, P_ISO);
        cyc(1, 0, 1, 0, 0, P_ISO);
        cyc(1, 0, 0, 0, 0, P_OFF);
        cyc(1, 0, 0, 0, 0, P_OFF);

        wake_up();
        cyc(1, 1, 1, 0, 0, P_ON);
        cyc(1, 1, 1, 0, 0, P_ON);
        cyc(1, 1, 0, 0, 1, P_ON);
        cyc(1, 0, 1, 0, 1, P_DRAIN);
        cyc(1, 0, 0, 0, 0, P_ON);
        cyc(1, 1, 0, 1, 0, P_ON);
        cyc(1, 1, 0, 0, 1, P_DRAIN);
        cyc(1, 1, 0, 0, 0, P_DRAIN);
        cyc(1, 0, 0, 0, 0, P_ISO);
        cyc(1, 0, 0, 0, 0, P_ISO);
        cyc(1, 0, 0, 0, 0, P_OFF);

        cyc(1, 0, 1, 0, 0, P_OFF);
        cyc(1, 0, 0, 0, 0, P_PWRUP);
        cyc(1, 0, 0, 0, 0, P_PWRUP);
        cyc(0, 0, 0, 0, 0, P_PWRUP);
        cyc(1, 0, 0, 0, 0, P_OFF);

`ifdef ALU_AUTO_SLEEP_EN
        wake_up();
        for (int i = 0; i < 3; i++)
            cyc(1, 0, 0, 0, 0, P_ON);
        cyc(1, 0, 0, 1, 0, P_ON);
        for (int i = 0; i < 4; i++)
            cyc(1, 0, 0, 0, 0, P_ON);
        cyc(1, 0, 0, 0, 0, P_DRAIN);
        cyc(1, 0, 0, 0, 0, P_ISO);
        cyc(1, 0, 0, 0, 0, P_ISO);
        cyc(1, 0, 0, 0, 0, P_OFF);
`endif

        for (int i = 0; i < 10 && q.size() > 0; i++)
            @(posedge clk);
        if (q.size() > 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain queue left %0d need 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
